// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the dual-port data memory.
package data_mem_pkg;

  typedef enum logic {CLEAR, READY} state_t;

  localparam int unsigned DATA_W_DFLT = 16;
  localparam int unsigned BE_W = DATA_W_DFLT / 8;

  // Even parity of one byte lane: the stored bit makes the 9-bit group even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/data_mem_rdpipe.sv
// Read pipeline: RD_LAT-deep valid/data stages; rd_data holds between valid reads.
// With PARITY_EN defined, checks stored lane parity and drives par_err alongside rd_valid.
module data_mem_rdpipe
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
`ifdef PARITY_EN
  ,
  input  logic [DATA_W/8-1:0] in_par,
  output logic                par_err
`endif
);

  logic              v1_q, v2_q;
  logic [DATA_W-1:0] d1_q, d2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      if (in_valid) d1_q <= in_data;
      if (v1_q)     d2_q <= d1_q;
    end
  end

  // The second stage is dead logic when RD_LAT is 1.
  assign rd_valid = (RD_LAT == 2) ? v2_q : v1_q;
  assign rd_data  = (RD_LAT == 2) ? d2_q : d1_q;

`ifdef PARITY_EN
  logic e_in, e1_q, e2_q;

  always_comb begin
    e_in = 1'b0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      e_in = e_in | (byte_parity(in_data[8*i +: 8]) != in_par[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_q <= 1'b0;
      e2_q <= 1'b0;
    end else begin
      e1_q <= in_valid & e_in;
      e2_q <= e1_q;
    end
  end

  assign par_err = (RD_LAT == 2) ? e2_q : e1_q;
`endif

endmodule

// File: rtl/data_mem_dp.sv
// Simple-dual-port data memory with byte enables, write-first bypass and a clear engine.
// Optional per-lane even parity and par_err output when PARITY_EN is defined.
module data_mem_dp
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  output logic                busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
`ifdef PARITY_EN
  ,
  output logic                par_err
`endif
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("data_mem_dp: RD_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("data_mem_dp: DATA_W must be a multiple of 8");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = READY;
      end
      READY: begin
        if (clr) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy = (state_q == CLEAR);

  // Write/clear mux: the clear engine owns the write port while busy.
  logic [LANES-1:0]  mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = '0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (busy) begin
      mem_we    = '1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (wr_en) begin
      mem_we = wr_be;
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_we[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  logic              rd_fire, collide;
  logic [DATA_W-1:0] rd_merged;

  assign rd_fire = rd_en & ~busy;
  assign collide = wr_en & ~busy & (wr_addr == rd_addr);

  always_comb begin
    rd_merged = mem[rd_addr];
    for (int i = 0; i < LANES; i++) begin
      if (collide && wr_be[i]) rd_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

`ifdef PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] par_merged;

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_we[i]) par_mem[mem_waddr][i] <= byte_parity(mem_wdata[8*i +: 8]);
    end
  end

  // Bypassed lanes carry parity of the fresh write data.
  always_comb begin
    par_merged = par_mem[rd_addr];
    for (int i = 0; i < LANES; i++) begin
      if (collide && wr_be[i]) par_merged[i] = byte_parity(wr_data[8*i +: 8]);
    end
  end
`endif

  data_mem_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_fire),
    .in_data  (rd_merged),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
`ifdef PARITY_EN
    ,
    .in_par   (par_merged),
    .par_err  (par_err)
`endif
  );

endmodule

// File: tb/tb_data_mem_dp.sv
// Bench for data_mem_dp: drives one RD_LAT=1 and one RD_LAT=2 instance with shared stimulus.
module tb_data_mem_dp;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [1:0]    wr_be = '0;
  logic [DW-1:0] wr_data = '0;

  logic          busy1, busy2, rv1, rv2;
  logic [DW-1:0] rd1, rd2;
`ifdef PARITY_EN
  logic          pe1, pe2;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] hold1 = '0;
  logic [DW-1:0] hold2 = '0;

  always #5 clk = ~clk;

  data_mem_dp #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd1), .rd_valid(rv1)
`ifdef PARITY_EN
    , .par_err(pe1)
`endif
  );

  data_mem_dp #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd2), .rd_valid(rv2)
`ifdef PARITY_EN
    , .par_err(pe2)
`endif
  );

  typedef struct {
    logic          do_wr;
    logic [AW-1:0] wa;
    logic [1:0]    be;
    logic [DW-1:0] wd;
    logic          do_rd;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of port activity, then checks of both latencies and of data hold.
  task automatic op(input string name, input logic do_wr, input logic [AW-1:0] wa,
                    input logic [1:0] be, input logic [DW-1:0] wd, input logic do_rd,
                    input logic [AW-1:0] ra, input logic [DW-1:0] exp);
    wr_en = do_wr; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = do_rd; rd_addr = ra;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    if (do_rd) hold1 = exp;
    check({name, " lat1 valid"}, rv1, do_rd);
    check({name, " lat1 data"}, rd1, hold1);
    check({name, " lat2 early valid"}, rv2, 1'b0);
    step();
    if (do_rd) hold2 = exp;
    check({name, " lat2 valid"}, rv2, do_rd);
    check({name, " lat2 data"}, rd2, hold2);
    check({name, " lat1 strobe end"}, rv1, 1'b0);
  endtask

  // Counts cycles with busy high; bounded so a stuck clear cannot hang the run.
  task automatic wait_clear(input string name);
    int   n;
    logic saw_rv;
    n = 0;
    saw_rv = 1'b0;
    while ((busy1 || busy2) && n < 5000) begin
      if (rv1 || rv2) saw_rv = 1'b1;
      step();
      n++;
    end
    check({name, " busy cycles"}, n, 4096);
    check({name, " no rd_valid while clearing"}, saw_rv, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 12'h010, 2'b11, 16'hBEEF, 1'b0, 12'h000, 16'h0000};
    vecs[1]  = '{1'b1, 12'h010, 2'b01, 16'h1234, 1'b0, 12'h000, 16'h0000};
    vecs[2]  = '{1'b0, 12'h000, 2'b00, 16'h0000, 1'b1, 12'h010, 16'hBE34};
    vecs[3]  = '{1'b1, 12'h020, 2'b11, 16'h5555, 1'b0, 12'h000, 16'h0000};
    vecs[4]  = '{1'b1, 12'h020, 2'b10, 16'hAAAA, 1'b1, 12'h020, 16'hAA55};
    vecs[5]  = '{1'b0, 12'h000, 2'b00, 16'h0000, 1'b1, 12'h020, 16'hAA55};
    vecs[6]  = '{1'b1, 12'hFFF, 2'b11, 16'hCAFE, 1'b0, 12'h000, 16'h0000};
    vecs[7]  = '{1'b1, 12'hFFF, 2'b00, 16'h0000, 1'b0, 12'h000, 16'h0000};
    vecs[8]  = '{1'b0, 12'h000, 2'b00, 16'h0000, 1'b1, 12'hFFF, 16'hCAFE};
    vecs[9]  = '{1'b1, 12'h000, 2'b10, 16'h1200, 1'b1, 12'h000, 16'h1200};
    vecs[10] = '{1'b1, 12'h030, 2'b11, 16'hA5A5, 1'b1, 12'h031, 16'h0000};
    vecs[11] = '{1'b1, 12'h031, 2'b01, 16'hFF77, 1'b1, 12'h030, 16'hA5A5};
    vecs[12] = '{1'b0, 12'h000, 2'b00, 16'h0000, 1'b1, 12'h031, 16'h0077};

    // Reset state, then the power-on clear with a read held on the port.
    rd_en = 1'b1;
    rd_addr = 12'h005;
    repeat (3) step();
    check("reset busy lat1", busy1, 1'b1);
    check("reset busy lat2", busy2, 1'b1);
    check("reset rd_valid lat1", rv1, 1'b0);
    check("reset rd_valid lat2", rv2, 1'b0);
    check("reset rd_data lat1", rd1, 16'h0000);
    check("reset rd_data lat2", rd2, 16'h0000);
    rst_n = 1'b1;
    wait_clear("power-on clear");
    rd_en = 1'b0;
    op("read cleared 0x005", 1'b0, '0, 2'b00, '0, 1'b1, 12'h005, 16'h0000);

    for (int i = 0; i < 13; i++) begin
      op($sformatf("vec%0d", i), vecs[i].do_wr, vecs[i].wa, vecs[i].be, vecs[i].wd,
         vecs[i].do_rd, vecs[i].ra, vecs[i].exp);
    end

    // Back-to-back reads: four consecutive strobes in order on each latency.
    for (int a = 1; a <= 4; a++) begin
      op($sformatf("preload %0d", a), 1'b1, AW'(a), 2'b11, DW'(16'h0100 + a),
         1'b0, '0, '0);
    end
    for (int k = 1; k <= 6; k++) begin
      rd_en = (k <= 4);
      rd_addr = AW'(k);
      step();
      rd_en = 1'b0;
      check($sformatf("burst lat1 valid k%0d", k), rv1, (k <= 4));
      if (k <= 4) check($sformatf("burst lat1 data k%0d", k), rd1, 16'h0100 + k);
      check($sformatf("burst lat2 valid k%0d", k), rv2, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) check($sformatf("burst lat2 data k%0d", k), rd2, 16'h0100 + k - 1);
    end
    hold1 = 16'h0104;
    hold2 = 16'h0104;

    // clr together with a read: the read still completes, then reset aborts the clear.
    clr = 1'b1;
    rd_en = 1'b1;
    rd_addr = 12'h010;
    step();
    clr = 1'b0;
    rd_en = 1'b0;
    check("clr entry busy", busy1, 1'b1);
    check("clr-cycle read lat1 valid", rv1, 1'b1);
    check("clr-cycle read lat1 data", rd1, 16'hBE34);
    step();
    check("clr-cycle read lat2 valid", rv2, 1'b1);
    check("clr-cycle read lat2 data", rd2, 16'hBE34);
    repeat (99) step();
    check("busy at clr_cnt 100", busy1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("busy in mid-clear reset", busy1, 1'b1);
    check("rd_data cleared by reset", rd2, 16'h0000);
    step();
    rst_n = 1'b1;
    hold1 = '0;
    hold2 = '0;
    wait_clear("restarted clear");
    begin
      logic [AW-1:0] addrs [10];
      addrs = '{12'h010, 12'h020, 12'hFFF, 12'h000, 12'h030,
                12'h031, 12'h001, 12'h002, 12'h003, 12'h004};
      for (int i = 0; i < 10; i++) begin
        op($sformatf("post-clear 0x%03h", addrs[i]), 1'b0, '0, 2'b00, '0, 1'b1, addrs[i],
           16'h0000);
      end
    end

`ifdef PARITY_EN
    op("par write 0x030", 1'b1, 12'h030, 2'b11, 16'hA5A5, 1'b0, '0, '0);
    rd_en = 1'b1;
    rd_addr = 12'h030;
    step();
    rd_en = 1'b0;
    check("clean read par_err lat1", pe1, 1'b0);
    step();
    check("clean read par_err lat2", pe2, 1'b0);
    u_dut1.mem[12'h030][3] = ~u_dut1.mem[12'h030][3];
    u_dut2.mem[12'h030][3] = ~u_dut2.mem[12'h030][3];
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("flipped read valid lat1", rv1, 1'b1);
    check("flipped read par_err lat1", pe1, 1'b1);
    check("par_err idle lat2", pe2, 1'b0);
    step();
    check("flipped read par_err lat2", pe2, 1'b1);
    check("par_err idle lat1", pe1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
